boot_verify: RTL and testbench

Read-back checker for the boot path. After the instruction memory has been loaded, it reads every word of boot memory and the matching instruction-memory location, compares the two, and reports pass/fail, the mismatch count and the first failing byte address. It sits beside the boot loader on the same two memory ports. It is the reader counterpart to the loader's writes into instruction memory.

---
 rtl/boot_verify.sv | 110 +++++++++++
 tb/tb_boot_verify.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_verify.sv
// rtl/boot_verify.sv - read-back checker comparing boot memory against instruction memory word by word
module boot_verify #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 20,
    parameter int WORD_COUNT = 'h120
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  boot_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] boot_mem_addr,
    input  logic [DATA_WIDTH-1:0] boot_mem_rd_data,
    output logic                  inst_mem_rd_en,
    output logic [ADDR_WIDTH-1:0] inst_mem_addr,
    input  logic [DATA_WIDTH-1:0] inst_mem_rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] ERR_MAX    = '1;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   index;
    logic [ADDR_WIDTH-1:0]   index_bytes;
    logic                    first_seen;
    logic                    launch;
    logic                    mismatch;

    // start is only honoured while no pass is running
    assign launch      = start && ((state == IDLE) || (state == DONE));
    assign mismatch    = (state == CMP) && (boot_mem_rd_data != inst_mem_rd_data);
    assign index_bytes = {index[ADDR_WIDTH-3:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        boot_mem_rd_en = 1'b0;
        inst_mem_rd_en = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = READ;
            end
            READ: begin
                boot_mem_rd_en = 1'b1;
                inst_mem_rd_en = 1'b1;
                busy           = 1'b1;
                state_next     = CMP;
            end
            CMP: begin
                busy       = 1'b1;
                state_next = (index == LAST_INDEX) ? DONE : READ;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = READ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
        end else if (launch) begin
            index          <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_seen     <= 1'b0;
        end else if (state == CMP) begin
            if (mismatch) begin
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
                if (!first_seen) begin
                    first_seen     <= 1'b1;
                    first_err_addr <= index_bytes;
                end
            end
            // index stops at the last word so DONE still reports it on the address bus
            if (index != LAST_INDEX) index <= index + 1'b1;
        end
    end

    assign boot_mem_addr = index;
    assign inst_mem_addr = index_bytes;
    assign pass          = done && (err_count == '0);

endmodule

// File: tb/tb_boot_verify.sv
// tb/tb_boot_verify.sv - randomized self-checking bench for boot_verify against a memory-image reference model
module tb_boot_verify;

    localparam int N   = 'h120;
    localparam int AW  = 20;
    localparam int DW  = 32;
    localparam int NS  = 4;
    localparam int AWS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          boot_mem_rd_en, inst_mem_rd_en;
    logic [AW-1:0] boot_mem_addr, inst_mem_addr;
    logic [DW-1:0] boot_mem_rd_data, inst_mem_rd_data;
    logic          busy, done, pass;
    logic [AW-1:0] err_count, first_err_addr;

    logic           start_s;
    logic           boot_rd_s, inst_rd_s;
    logic [AWS-1:0] boot_addr_s, inst_addr_s;
    logic [DW-1:0]  boot_data_s, inst_data_s;
    logic           busy_s, done_s, pass_s;
    logic [AWS-1:0] err_s, first_s;

    logic [DW-1:0] boot_img [N];
    logic [DW-1:0] inst_img [N];
    logic [DW-1:0] boot_img_s [NS];
    logic [DW-1:0] inst_img_s [NS];

    int total = 0;
    int bad   = 0;
    int strobes;
    bit mon_en = 1'b0;
    logic prev_rd;

    always #5 clk = ~clk;

    boot_verify #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WORD_COUNT(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .boot_mem_rd_en(boot_mem_rd_en), .boot_mem_addr(boot_mem_addr), .boot_mem_rd_data(boot_mem_rd_data),
        .inst_mem_rd_en(inst_mem_rd_en), .inst_mem_addr(inst_mem_addr), .inst_mem_rd_data(inst_mem_rd_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr)
    );

    boot_verify #(.DATA_WIDTH(DW), .ADDR_WIDTH(AWS), .WORD_COUNT(NS)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .boot_mem_rd_en(boot_rd_s), .boot_mem_addr(boot_addr_s), .boot_mem_rd_data(boot_data_s),
        .inst_mem_rd_en(inst_rd_s), .inst_mem_addr(inst_addr_s), .inst_mem_rd_data(inst_data_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .err_count(err_s), .first_err_addr(first_s)
    );

    // memories return data the cycle after the strobe
    always @(posedge clk) begin
        if (boot_mem_rd_en) boot_mem_rd_data <= (int'(boot_mem_addr) < N) ? boot_img[boot_mem_addr] : '0;
        if (inst_mem_rd_en) inst_mem_rd_data <= (int'(inst_mem_addr >> 2) < N) ? inst_img[inst_mem_addr >> 2] : '0;
        if (boot_rd_s) boot_data_s <= boot_img_s[boot_addr_s[1:0]];
        if (inst_rd_s) inst_data_s <= inst_img_s[inst_addr_s[3:2]];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (boot_mem_rd_en) begin
                check("boot_addr", 64'(boot_mem_addr), 64'(strobes));
                check("inst_addr", 64'(inst_mem_addr), 64'(strobes * 4));
                check("inst_rd_en", 64'(inst_mem_rd_en), 64'd1);
                check("no_consec_rd", 64'(prev_rd), 64'd0);
                strobes++;
            end
            prev_rd = boot_mem_rd_en;
        end
    end

    // reference: count differing words, saturate, report byte address of the lowest one
    task automatic model(output int exp_err, output int exp_first);
        exp_err   = 0;
        exp_first = -1;
        for (int i = 0; i < N; i++) begin
            if (boot_img[i] != inst_img[i]) begin
                exp_err++;
                if (exp_first < 0) exp_first = (i * 4) % (1 << AW);
            end
        end
        if (exp_err > (1 << AW) - 1) exp_err = (1 << AW) - 1;
        if (exp_first < 0) exp_first = 0;
    endtask

    task automatic run_pass(input int p1, input int p2, input bit chk_clear, output int edges);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        strobes = 0;
        prev_rd = 1'b0;
        mon_en  = 1'b1;
        if (chk_clear) begin
            check("clr_err", 64'(err_count), 64'd0);
            check("clr_first", 64'(first_err_addr), 64'd0);
            check("clr_busy", 64'(busy), 64'd1);
            check("clr_done", 64'(done), 64'd0);
        end
        edges = 0;
        while (edges < 2 * N + 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done) break;
            start = (edges == p1) || (edges == p2);
        end
        start  = 1'b0;
        mon_en = 1'b0;
    endtask

    task automatic verify_pass(input string tag, input int edges);
        int exp_err, exp_first;
        model(exp_err, exp_first);
        check({tag, "_edges"}, 64'(edges), 64'(2 * N));
        check({tag, "_strobes"}, 64'(strobes), 64'(N));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pass"}, 64'(pass), 64'(exp_err == 0));
        check({tag, "_err"}, 64'(err_count), 64'(exp_err));
        check({tag, "_first"}, 64'(first_err_addr), 64'(exp_first));
    endtask

    task automatic clean_images(input bit ramp);
        for (int i = 0; i < N; i++) begin
            boot_img[i] = ramp ? 32'(i) * 32'h01010101 : $urandom;
            inst_img[i] = boot_img[i];
        end
    endtask

    function automatic logic [DW-1:0] flip(input logic [DW-1:0] w);
        logic [DW-1:0] m;
        m = 32'(1) << $urandom_range(31, 0);
        return w ^ m;
    endfunction

    initial begin
        int edges;
        int k;
        rst_n   = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        clean_images(1'b1);
        for (int i = 0; i < NS; i++) begin
            boot_img_s[i] = $urandom;
            inst_img_s[i] = ~boot_img_s[i];
        end
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_rd_en", 64'({boot_mem_rd_en, inst_mem_rd_en}), 64'd0);
        check("rst_addr", 64'({boot_mem_addr, inst_mem_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(-1, -1, 1'b0, edges);
        verify_pass("ramp_clean", edges);

        inst_img[5] = flip(inst_img[5]);
        run_pass(-1, -1, 1'b0, edges);
        verify_pass("word5", edges);

        clean_images(1'b1);
        inst_img[3]     = flip(inst_img[3]);
        inst_img[N - 1] = flip(inst_img[N - 1]);
        run_pass(10, 100, 1'b0, edges);
        verify_pass("w3_last_restart", edges);
        check("w3_last_first_lit", 64'(first_err_addr), 64'h0C);

        run_pass(-1, -1, 1'b0, edges);
        verify_pass("rerun_err2", edges);
        clean_images(1'b0);
        run_pass(-1, -1, 1'b1, edges);
        verify_pass("from_done_clean", edges);

        for (int r = 0; r < 3; r++) begin
            clean_images(1'b0);
            k = $urandom_range(6, 0);
            for (int j = 0; j < k; j++) begin
                int w;
                w = $urandom_range(N - 1, 0);
                inst_img[w] = flip(inst_img[w]);
            end
            run_pass($urandom_range(2 * N - 2, 1), -1, 1'b0, edges);
            verify_pass($sformatf("rand%0d", r), edges);
        end

        inst_img[2] = flip(inst_img[2]);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            if (boot_mem_addr == AW'(64)) break;
            k++;
        end
        check("reached_idx40", 64'(boot_mem_addr), 64'h40);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done_pass", 64'({done, pass}), 64'd0);
        check("arst_err", 64'(err_count), 64'd0);
        check("arst_first", 64'(first_err_addr), 64'd0);
        check("arst_rd_en", 64'({boot_mem_rd_en, inst_mem_rd_en}), 64'd0);
        check("arst_addr", 64'({boot_mem_addr, inst_mem_addr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clean_images(1'b0);
        run_pass(-1, -1, 1'b0, edges);
        verify_pass("after_reset", edges);

        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1;
        start_s = 1'b0;
        edges = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done_s) break;
        end
        check("small_edges", 64'(edges), 64'(2 * NS));
        check("small_err", 64'(err_s), 64'd4);
        check("small_first", 64'(first_s), 64'd0);
        check("small_pass", 64'(pass_s), 64'd0);
        check("small_done", 64'(done_s), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
